// File: rtl/rv_mdu_if.sv
// Start/done handshake bundle between the multicycle control path and rv_mdu.
// The control side drives the request (master); the unit answers (slave).
interface rv_mdu_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output start, op, src_a, src_b, kill,
    input  busy, done, result, illegal
  );

  modport slave (
    input  start, op, src_a, src_b, kill,
    output busy, done, result, illegal
  );
endinterface

// File: rtl/rv_mdu.sv
// rv_mdu: iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiplier and restoring divider on operand magnitudes,
// sign fixed up in FIN. Divide-by-zero and signed overflow finish in one cycle.
// Build option: define RV_MDU_DIV_EN to include the divider; without it every
// op[2]=1 request finishes in one cycle with result 0 and illegal set.
module rv_mdu #(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  rv_mdu_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic                neg_q, neg_d;
  logic                spec_q, spec_d;
  logic [XLEN-1:0]     spec_res_q, spec_res_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;

  // Start-cycle operand decode
  logic                a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]     a_mag_s, b_mag_s;
  logic                spec_s;
  logic [XLEN-1:0]     spec_val_s;
  logic [2*XLEN-1:0]   add_s, prod_s;

  // Only MULHU/DIVU/REMU treat rs1 as unsigned; MULHSU additionally treats rs2 as unsigned.
  assign a_sgn_s = bus.op[2] ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
  assign b_sgn_s = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
  assign a_neg_s = a_sgn_s & bus.src_a[XLEN-1];
  assign b_neg_s = b_sgn_s & bus.src_b[XLEN-1];
  assign a_mag_s = a_neg_s ? -bus.src_a : bus.src_a;
  assign b_mag_s = b_neg_s ? -bus.src_b : bus.src_b;

  assign add_s  = acc_q + mcand_q;
  assign prod_s = neg_q ? -acc_q : acc_q;

`ifdef RV_MDU_DIV_EN
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     dvsr_q, dvsr_d;
  logic                negr_q, negr_d;
  logic                dz_s, ovf_s, ge_s;
  logic [XLEN:0]       rem_sh_s;
  logic [XLEN-1:0]     sub_s, quo_res_s, rem_res_s;

  assign dz_s  = bus.op[2] & (bus.src_b == {XLEN{1'b0}});
  assign ovf_s = bus.op[2] & ~bus.op[0] & (bus.src_a == MIN_NEG) & (bus.src_b == {XLEN{1'b1}});
  assign spec_s = dz_s | ovf_s;
  assign spec_val_s = dz_s ? (bus.op[1] ? bus.src_a : {XLEN{1'b1}})
                           : (bus.op[1] ? {XLEN{1'b0}} : bus.src_a);

  // Partial remainder shifted left with the next dividend bit (XLEN+1 bits).
  assign rem_sh_s  = {rem_q, quo_q[XLEN-1]};
  assign ge_s      = (rem_sh_s >= {1'b0, dvsr_q});
  // When ge_s holds the true difference is below the divisor, so XLEN bits suffice.
  assign sub_s     = rem_sh_s[XLEN-1:0] - dvsr_q;
  assign quo_res_s = neg_q  ? -quo_q : quo_q;
  assign rem_res_s = negr_q ? -rem_q : rem_q;
`else
  assign spec_s     = bus.op[2];
  assign spec_val_s = {XLEN{1'b0}};
`endif

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.illegal = illegal_q;

  // Next-state and datapath update; kill overrides everything and returns to IDLE.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    result_d   = result_q;
    done_d     = 1'b0;
    illegal_d  = illegal_q;
`ifdef RV_MDU_DIV_EN
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    negr_d     = negr_q;
`endif
    if (bus.kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            op_d       = bus.op;
            cnt_d      = {CW{1'b0}};
            acc_d      = {(2*XLEN){1'b0}};
            mcand_d    = {{XLEN{1'b0}}, a_mag_s};
            mplier_d   = b_mag_s;
            neg_d      = a_neg_s ^ b_neg_s;
            spec_d     = spec_s;
            spec_res_d = spec_val_s;
            illegal_d  = 1'b0;
`ifdef RV_MDU_DIV_EN
            rem_d      = {XLEN{1'b0}};
            quo_d      = a_mag_s;
            dvsr_d     = b_mag_s;
            negr_d     = a_neg_s;
`endif
            if (spec_s) begin
              state_d = ST_FIN;
            end else if (bus.op[2]) begin
              state_d = ST_DIV;
            end else begin
              state_d = ST_MUL;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mplier_q[0]) begin
            acc_d = add_s;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[XLEN-1:1]};
          if (cnt_q == CW'(XLEN-1)) begin
            state_d = ST_FIN;
          end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
`ifdef RV_MDU_DIV_EN
        ST_DIV: begin
          if (ge_s) begin
            rem_d = sub_s;
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_sh_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == CW'(XLEN-1)) begin
            state_d = ST_FIN;
          end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
`endif
        ST_FIN: begin
          if (spec_q) begin
            result_d = spec_res_q;
`ifdef RV_MDU_DIV_EN
          end else if (op_q[2]) begin
            result_d = op_q[1] ? rem_res_s : quo_res_s;
`endif
          end else if (op_q[1:0] == 2'b00) begin
            result_d = prod_s[XLEN-1:0];
          end else begin
            result_d = prod_s[2*XLEN-1:XLEN];
          end
`ifdef RV_MDU_DIV_EN
          illegal_d = 1'b0;
`else
          illegal_d = op_q[2];
`endif
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      op_q       <= 3'b000;
      cnt_q      <= {CW{1'b0}};
      acc_q      <= {(2*XLEN){1'b0}};
      mcand_q    <= {(2*XLEN){1'b0}};
      mplier_q   <= {XLEN{1'b0}};
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= {XLEN{1'b0}};
      result_q   <= {XLEN{1'b0}};
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef RV_MDU_DIV_EN
      rem_q      <= {XLEN{1'b0}};
      quo_q      <= {XLEN{1'b0}};
      dvsr_q     <= {XLEN{1'b0}};
      negr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      result_q   <= result_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
`ifdef RV_MDU_DIV_EN
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      negr_q     <= negr_d;
`endif
    end
  end

endmodule

// File: tb/tb_rv_mdu.sv
// Self-checking bench for rv_mdu (XLEN=32). Expected results are queued when a
// request is issued and compared when done pulses. Expectations adapt to the
// RV_MDU_DIV_EN build option.
module tb_rv_mdu;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          t0;
    string       nm;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc_cnt = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  exp_t sb_q[$];

  rv_mdu_if #(.XLEN(XLEN)) bus ();

  rv_mdu #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // free-running cycle counter used for latency measurement
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Reference model: RISC-V M semantics using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu;
    logic        [63:0] p;
    logic signed [31:0] as32, bs32;
    logic        [31:0] r;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    sbu  = {32'h0, b};
    as32 = a;
    bs32 = b;
    r    = 32'h0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * sbu; r = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'h0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = as32 / bs32;
      end
      3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = as32 % bs32;
      end
      default: r = (b == 32'h0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one request; returns #1 after the accepting edge E0.
  task automatic start_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input bit push);
    exp_t e;
    bit   special;
    special = op[2] && (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    e.res = exp_res;
    e.ill = 1'b0;
    e.lat = special ? 1 : 33;
    e.nm  = nm;
`ifndef RV_MDU_DIV_EN
    if (op[2]) begin
      e.res = 32'h0;
      e.ill = 1'b1;
      e.lat = 1;
    end
`endif
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e.t0 = cyc_cnt;
    if (push) sb_q.push_back(e);
  endtask

  // Wait (bounded) for done, pop the scoreboard and compare.
  task automatic wait_done();
    exp_t e;
    int   guard;
    bit   busy_ok;
    guard   = 0;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && guard < 200) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: got done with no queued entry, required 1 entry");
      return;
    end
    e = sb_q.pop_front();
    if (bus.done !== 1'b1) begin
      n_err++;
      $display("FAIL %s timeout: done=%b, required 1 within 200 cycles", e.nm, bus.done);
      return;
    end
    n_cmp++;
    if (bus.result !== e.res) begin
      n_err++;
      $display("FAIL %s result: got %h required %h", e.nm, bus.result, e.res);
    end
    n_cmp++;
    if (bus.illegal !== e.ill) begin
      n_err++;
      $display("FAIL %s illegal: got %b required %b", e.nm, bus.illegal, e.ill);
    end
    n_cmp++;
    if (cyc_cnt - e.t0 !== e.lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d required %0d", e.nm, cyc_cnt - e.t0, e.lat);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || busy_ok !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy: busy_at_done=%b busy_held=%b required 0/1", e.nm, bus.busy, busy_ok);
    end
  endtask

  // Count done pulses over a window; used where no completion is allowed.
  task automatic expect_quiet(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL %s spurious done: got %0d pulses required 0", nm, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.illegal} !== 3'b000 || bus.result !== 32'h0) begin
      n_err++;
      $display("FAIL reset: got busy=%b done=%b illegal=%b result=%h required 0 0 0 0",
               bus.busy, bus.done, bus.illegal, bus.result);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    start_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1); wait_done();
    start_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1); wait_done();
    start_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_done();
    start_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1); wait_done();
  endtask

  task automatic test_div();
    start_op("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1); wait_done();
    start_op("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1); wait_done();
    start_op("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14, 1'b1); wait_done();
    start_op("remu_100/7", 3'd7, 32'd100, 32'd7, 32'd2, 1'b1); wait_done();
    start_op("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1); wait_done();
    start_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 1'b1); wait_done();
    start_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); wait_done();
    start_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1); wait_done();
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'($urandom_range(1, 15)) : $urandom;
      start_op($sformatf("rand%0d_op%0d", i, op), op, a, b, model(op, a, b), 1'b1);
      wait_done();
    end
  endtask

  task automatic test_back_to_back();
    start_op("b2b_first", 3'd0, 32'd1234, 32'd5678, 32'd7006652, 1'b1);
    wait_done();
    // start is driven inside the done cycle
    start_op("b2b_second", 3'd3, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 1'b1);
    n_cmp++;
    if (bus.result !== 32'd7006652) begin
      n_err++;
      $display("FAIL b2b_hold: got %h required %h", bus.result, 32'd7006652);
    end
    wait_done();
  endtask

  task automatic test_start_busy();
    start_op("busy_first", 3'd0, 32'hFFFF_FFFF, 32'd9, 32'hFFFF_FFF7, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.op = 3'd0; bus.src_a = 32'd3; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done();
    expect_quiet("busy_ignored", 40);
  endtask

  task automatic test_kill();
    start_op("kill_prev", 3'd0, 32'd11, 32'd13, 32'd143, 1'b1);
    wait_done();
    start_op("kill_victim", 3'd0, 32'h0012_3456, 32'h0000_0777, 32'h0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end
    bus.kill = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL kill_idle: got busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    expect_quiet("kill_no_done", 40);
    n_cmp++;
    if (bus.result !== 32'd143) begin
      n_err++;
      $display("FAIL kill_result: got %h required %h", bus.result, 32'd143);
    end
    start_op("after_kill", 3'd0, 32'd6, 32'd7, 32'd42, 1'b1);
    wait_done();
  endtask

  task automatic test_reset_mid();
    start_op("rst_victim", 3'd0, 32'd99, 32'd99, 32'h0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.illegal} !== 3'b000 || bus.result !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid: got busy=%b done=%b illegal=%b result=%h required 0 0 0 0",
               bus.busy, bus.done, bus.illegal, bus.result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    start_op("after_rst", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b1);
    wait_done();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.src_a = 32'h0;
    bus.src_b = 32'h0;
    bus.kill  = 1'b0;
    rst       = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_back_to_back();
    test_start_busy();
    test_kill();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
